writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Writeback stage in front of the register file. It merges single-cycle pipeline results with results from long-latency units (divider, FPU, load miss), and drives one registered write per cycle onto the register file write port (6-bit ID, bit 5 selects the FP bank). Long-latency results are buffered in a small FIFO. A starvation counter forces a pipeline stall so buffered results always drain.

## Interface
- `FIFO_DEPTH`, default 4: long-latency result buffer entries; power of 2, ≥2.
- `STARVE_LIMIT`, default 8: consecutive cycles the FIFO head may wait before a forced stall; ≥1.

Ports:
- `clk_i`  in  1  clock.
- `resetn_i`  in  1  reset; synchronous, active-low.
- `pipeValid_i`  in  1  pipeline result present this cycle; no backpressure except `pipeStall_o`.
- `pipeId_i`  in  6  pipeline destination ID.
- `pipeData_i`  in  32  pipeline result.
- `pipeStall_o`  out  1  registered; pipeline must hold its result while high, and `pipeValid_i` is ignored.
- `mcValid_i`  in  1  long-latency result valid.
- `mcId_i`  in  6  long-latency destination ID.
- `mcData_i`  in  32  long-latency result.
- `mcReady_o`  out  1  FIFO can accept; a transfer happens when `mcValid_i && mcReady_o`.
- `mcPending_o`  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `rdId_o`  out  6  register file write ID; 6'd0 means no write.
- `rdData_o`  out  32  register file write data.

## Operation
- Drop rule: any result with ID[4:0]==0 (x0 or F0) is discarded. A long-latency handshake still completes for such a result, but nothing is enqueued.
- FIFO: circular buffer with read and write pointers plus an occupancy count.
  - Push on handshake (when not dropped).
  - Pop when the head is granted.
  - `mcReady_o` = count < FIFO_DEPTH. A full FIFO refuses a push even in a cycle it pops.
- Grant priority, evaluated each cycle:
  1. If `pipeStall_o`=1 and the FIFO is non-empty: grant the FIFO head. The pipeline input is ignored.
  2. Else if `pipeValid_i` is set and not dropped: grant the pipeline.
  3. Else if the FIFO is non-empty: grant the FIFO head.
  4. Else: idle, with `rdId_o` ← 6'd0 and `rdData_o` ← 32'h0.
- The granted ID and data are registered into `rdId_o` and `rdData_o`.
- Starvation counter `starveCnt`, width clog2(STARVE_LIMIT+1):
  - Reset to 0 on a FIFO pop or when the FIFO is empty.
  - Otherwise increment, saturating at STARVE_LIMIT.
  - `pipeStall_o` is registered and equals (next `starveCnt` == STARVE_LIMIT).
  - A stall cycle always pops, so `pipeStall_o` lasts exactly one cycle per starvation event.
- FIFO ordering: strict FIFO. Long-latency results retire in arrival order.
- Same-ID collisions: if the pipeline and a FIFO entry target the same ID, write order follows grant order. Scoreboarding upstream prevents WAW hazards; this block does not check for them.

## Timing
- Latency is 1 cycle. A result granted in cycle N appears on `rdId_o`/`rdData_o` in cycle N+1 and is written into the register file at the end of N+1.
- Long-latency minimum latency is 2 cycles: handshake in N, then output in N+2 at the earliest (the FIFO is always registered; no bypass around it).
- Reset values while `resetn_i` is low, and on the first cycle after it rises:
  - `rdId_o`=6'd0, `rdData_o`=0, `pipeStall_o`=0.
  - `mcPending_o`=0, FIFO pointers and count 0, `starveCnt`=0.
  - `mcReady_o` is forced to 0 while `resetn_i` is low and is 1 afterwards.
- Reset mid-operation: all buffered entries are lost. The upstream units are reset by the same signal.
- Pointer wrap-around is modulo FIFO_DEPTH. Count distinguishes full from empty.
- Simultaneous push and pop with the FIFO non-full: count is unchanged and both pointers advance.

## Configuration
- `WB_BYPASS_EN`: when defined, adds the following ports:
  - `rs1Id_i`/`rs2Id_i` (in, 6) and `rs1Hit_o`/`rs2Hit_o` (out, 1).
  - `rsNHit_o` = (`rsNId_i` == `rdId_o`) && (`rdId_o[4:0]` != 0). This is combinational.
  - On a hit, decode substitutes `rdData_o` for the register file read data, which would otherwise be stale in the write cycle.
- When `WB_BYPASS_EN` is undefined, these ports do not exist and decode must stall one cycle on a same-ID read.

## Test plan
- Pipeline-only traffic: `pipeValid_i`=1 with ID 6'd5 / 0xDEADBEEF, then ID 6'h25 / 0x3F800000 → `rdId_o`=5 then 0x25 with matching data one cycle later each; register file x5 and f5 are updated.
- Drop rule: pipeline ID 6'd0 and long-latency ID 6'h20, each with data 0x1234 → `rdId_o` stays 0, `mcPending_o` stays 0, and the long-latency handshake still completes.
- FIFO fill: 5 long-latency pushes (IDs 1..5) while the pipeline is continuously valid, `FIFO_DEPTH`=4 → `mcReady_o`=0 after the 4th push and the 5th is held off.
- Starvation: after the fill, pipeline stays valid → `pipeStall_o`=1 after 8 waiting cycles, ID 1 is written in the stall cycle, and the pattern repeats until IDs 1..4 have retired in order.
- Idle drain and reset: 3 entries buffered and pipeline idle → written on 3 consecutive cycles. Assert `resetn_i`=0 with 2 entries buffered → next cycle `mcPending_o`=0 and `rdId_o`=0, and no buffered writes appear after reset releases.
- With `WB_BYPASS_EN`: write ID 7 in flight and `rs1Id_i`=7 → `rs1Hit_o`=1; `rs2Id_i`=6'h27 → `rs2Hit_o`=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges pipeline and long-latency results into one registered register-file write per cycle.
// Optional feature macro: WB_BYPASS_EN adds rs1/rs2 hit outputs so decode can forward the write-port value.
module writeback_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic                        pipeValid_i,
  input  logic [5:0]                  pipeId_i,
  input  logic [31:0]                 pipeData_i,
  output logic                        pipeStall_o,
  input  logic                        mcValid_i,
  input  logic [5:0]                  mcId_i,
  input  logic [31:0]                 mcData_i,
  output logic                        mcReady_o,
  output logic [$clog2(FIFO_DEPTH):0] mcPending_o,
`ifdef WB_BYPASS_EN
  input  logic [5:0]                  rs1Id_i,
  input  logic [5:0]                  rs2Id_i,
  output logic                        rs1Hit_o,
  output logic                        rs2Hit_o,
`endif
  output logic [5:0]                  rdId_o,
  output logic [31:0]                 rdData_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_FIFO
  } grant_e;

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] data;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             stall_q, stall_d;
  logic [5:0]       rdId_q, rdId_d;
  logic [31:0]      rdData_q, rdData_d;

  logic   fifoEmpty;
  logic   fifoFull;
  logic   push;
  logic   pop;
  logic   pipeKeep;
  entry_t head;
  grant_e grant;

  // Handshake still completes for x0/F0 results; they are simply never enqueued.
  always_comb begin
    fifoEmpty = (count_q == '0);
    fifoFull  = (count_q == DEPTH_C);
    mcReady_o = resetn_i && !fifoFull;
    push      = mcValid_i && mcReady_o && (mcId_i[4:0] != 5'd0);
    pipeKeep  = pipeValid_i && (pipeId_i[4:0] != 5'd0);
    head      = mem_q[rdPtr_q];
  end

  always_comb begin
    grant = GRANT_NONE;
    if (stall_q) begin
      if (!fifoEmpty) begin
        grant = GRANT_FIFO;
      end
    end else if (pipeKeep) begin
      grant = GRANT_PIPE;
    end else if (!fifoEmpty) begin
      grant = GRANT_FIFO;
    end
  end

  always_comb begin
    pop      = (grant == GRANT_FIFO);
    rdId_d   = 6'd0;
    rdData_d = 32'h0;
    case (grant)
      GRANT_PIPE: begin
        rdId_d   = pipeId_i;
        rdData_d = pipeData_i;
      end
      GRANT_FIFO: begin
        rdId_d   = head.id;
        rdData_d = head.data;
      end
      default: begin
      end
    endcase

    wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // The stall cycle always pops, which clears the counter and drops the stall again.
    if (pop || fifoEmpty) begin
      starve_d = '0;
    end else if (starve_q == LIMIT_C) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + SC_W'(1);
    end
    stall_d = (starve_d == LIMIT_C);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      rdId_q   <= 6'd0;
      rdData_q <= 32'h0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      rdId_q   <= rdId_d;
      rdData_q <= rdData_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q] <= '{id: mcId_i, data: mcData_i};
    end
  end

  assign pipeStall_o = stall_q;
  assign mcPending_o = count_q;
  assign rdId_o      = rdId_q;
  assign rdData_o    = rdData_q;

`ifdef WB_BYPASS_EN
  assign rs1Hit_o = (rs1Id_i == rdId_q) && (rdId_q[4:0] != 5'd0);
  assign rs2Hit_o = (rs2Id_i == rdId_q) && (rdId_q[4:0] != 5'd0);
`else
  // Without the bypass, decode must stall one cycle when it reads the ID being written.
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a per-cycle vector table plus hand-written starvation and bypass sequences.
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        pipeValid;
  logic [5:0]  pipeId;
  logic [31:0] pipeData;
  logic        pipeStall;
  logic        mcValid;
  logic [5:0]  mcId;
  logic [31:0] mcData;
  logic        mcReady;
  logic [2:0]  mcPending;
  logic [5:0]  rdId;
  logic [31:0] rdData;
`ifdef WB_BYPASS_EN
  logic [5:0]  rs1Id;
  logic [5:0]  rs2Id;
  logic        rs1Hit;
  logic        rs2Hit;
`endif

  int checkCount = 0;
  int missCount  = 0;

  always #5 clock = ~clock;

  writeback_arbiter #(
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_i      (clock),
    .resetn_i   (resetn),
    .pipeValid_i(pipeValid),
    .pipeId_i   (pipeId),
    .pipeData_i (pipeData),
    .pipeStall_o(pipeStall),
    .mcValid_i  (mcValid),
    .mcId_i     (mcId),
    .mcData_i   (mcData),
    .mcReady_o  (mcReady),
    .mcPending_o(mcPending),
`ifdef WB_BYPASS_EN
    .rs1Id_i    (rs1Id),
    .rs2Id_i    (rs2Id),
    .rs1Hit_o   (rs1Hit),
    .rs2Hit_o   (rs2Hit),
`endif
    .rdId_o     (rdId),
    .rdData_o   (rdData)
  );

  // One record per clock cycle: inputs driven before the edge, outputs expected just after it.
  typedef struct {
    logic        resetn;
    logic        pipeValid;
    logic [5:0]  pipeId;
    logic [31:0] pipeData;
    logic        mcValid;
    logic [5:0]  mcId;
    logic [31:0] mcData;
    logic [5:0]  expId;
    logic [31:0] expData;
    logic        expStall;
    logic        expReady;
    logic [2:0]  expPending;
  } WbVector;

  WbVector vectors[$];

  function automatic WbVector mkVec(input logic rn, input logic pv, input logic [5:0] pid,
                                    input logic [31:0] pd, input logic mv, input logic [5:0] mid,
                                    input logic [31:0] md, input logic [5:0] eid, input logic [31:0] ed,
                                    input logic es, input logic er, input logic [2:0] ep);
    WbVector v;
    v.resetn     = rn;
    v.pipeValid  = pv;
    v.pipeId     = pid;
    v.pipeData   = pd;
    v.mcValid    = mv;
    v.mcId       = mid;
    v.mcData     = md;
    v.expId      = eid;
    v.expData    = ed;
    v.expStall   = es;
    v.expReady   = er;
    v.expPending = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input WbVector v);
    resetn    = v.resetn;
    pipeValid = v.pipeValid;
    pipeId    = v.pipeId;
    pipeData  = v.pipeData;
    mcValid   = v.mcValid;
    mcId      = v.mcId;
    mcData    = v.mcData;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int          expPend;
    int          seq;
    int          k;
    logic        stallNow;
    logic        expStall;
    logic [5:0]  expId;
    logic [31:0] expData;

    resetn    = 1'b0;
    pipeValid = 1'b0;
    pipeId    = 6'd0;
    pipeData  = 32'h0;
    mcValid   = 1'b0;
    mcId      = 6'd0;
    mcData    = 32'h0;
`ifdef WB_BYPASS_EN
    rs1Id     = 6'd0;
    rs2Id     = 6'd0;
`endif

    //                    rn  pv  pid    pdata          mv  mid    mdata        eid    edata          es  er  ep
    vectors.push_back(mkVec(0, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 0, 3'd0));
    vectors.push_back(mkVec(0, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 0, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 1, 3'd0));
    vectors.push_back(mkVec(1, 1, 6'd5,  32'hDEADBEEF,  0, 6'd0,  32'h0,       6'd5,  32'hDEADBEEF,  0, 1, 3'd0));
    vectors.push_back(mkVec(1, 1, 6'h25, 32'h3F800000,  0, 6'd0,  32'h0,       6'h25, 32'h3F800000,  0, 1, 3'd0));
    vectors.push_back(mkVec(1, 1, 6'd0,  32'h1234,      1, 6'h20, 32'h1234,    6'd0,  32'h0,         0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 1, 3'd0));
    vectors.push_back(mkVec(1, 1, 6'd9,  32'h99,        1, 6'd3,  32'hA3,      6'd9,  32'h99,        0, 1, 3'd1));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd3,  32'hA3,        0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         1, 6'd4,  32'hA4,      6'd0,  32'h0,         0, 1, 3'd1));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd4,  32'hA4,        0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         1, 6'd10, 32'hB0,      6'd0,  32'h0,         0, 1, 3'd1));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         1, 6'd11, 32'hB1,      6'd10, 32'hB0,        0, 1, 3'd1));
    vectors.push_back(mkVec(1, 1, 6'h21, 32'hC1,        1, 6'h2C, 32'hB2,      6'h21, 32'hC1,        0, 1, 3'd2));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd11, 32'hB1,        0, 1, 3'd1));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         1, 6'h20, 32'h1234,    6'h2C, 32'hB2,        0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         1, 6'd13, 32'hD3,      6'd0,  32'h0,         0, 1, 3'd1));
    vectors.push_back(mkVec(1, 1, 6'h20, 32'h1234,      0, 6'd0,  32'h0,       6'd13, 32'hD3,        0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 1, 3'd0));
    // Three entries buffered behind a busy pipeline, then drained on consecutive idle cycles.
    vectors.push_back(mkVec(1, 1, 6'd9,  32'hF0,        1, 6'h21, 32'hE1,      6'd9,  32'hF0,        0, 1, 3'd1));
    vectors.push_back(mkVec(1, 1, 6'd9,  32'hF1,        1, 6'h22, 32'hE2,      6'd9,  32'hF1,        0, 1, 3'd2));
    vectors.push_back(mkVec(1, 1, 6'd9,  32'hF2,        1, 6'h23, 32'hE3,      6'd9,  32'hF2,        0, 1, 3'd3));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'h21, 32'hE1,        0, 1, 3'd2));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'h22, 32'hE2,        0, 1, 3'd1));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'h23, 32'hE3,        0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 1, 3'd0));
    // Reset with two entries buffered: they must never reach the write port.
    vectors.push_back(mkVec(1, 1, 6'd9,  32'hF3,        1, 6'd14, 32'h1E,      6'd9,  32'hF3,        0, 1, 3'd1));
    vectors.push_back(mkVec(1, 1, 6'd9,  32'hF4,        1, 6'd15, 32'h1F,      6'd9,  32'hF4,        0, 1, 3'd2));
    vectors.push_back(mkVec(0, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 0, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 1, 3'd0));
    vectors.push_back(mkVec(1, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,       6'd0,  32'h0,         0, 1, 3'd0));

    foreach (vectors[i]) begin
      applyStimulus(vectors[i]);
      checkOutput($sformatf("v%0d rdId", i),      32'(rdId),      32'(vectors[i].expId));
      checkOutput($sformatf("v%0d rdData", i),    rdData,         vectors[i].expData);
      checkOutput($sformatf("v%0d pipeStall", i), 32'(pipeStall), 32'(vectors[i].expStall));
      checkOutput($sformatf("v%0d mcReady", i),   32'(mcReady),   32'(vectors[i].expReady));
      checkOutput($sformatf("v%0d mcPending", i), 32'(mcPending), 32'(vectors[i].expPending));
    end

    // Fill the FIFO behind a continuously valid pipeline, then let starvation drain IDs 1..4.
    // Head waits from cycle 2, so stalls are visible after cycles 9, 18, 27, 36 and pops land on 10, 19, 28, 37.
    expPend = 0;
    seq     = 0;
    for (int c = 1; c <= 40; c++) begin
      stallNow  = (c >= 10) && (c <= 37) && (((c - 1) % 9) == 0);
      pipeValid = 1'b1;
      pipeId    = 6'd8;
      pipeData  = 32'hA000_0000 + 32'(seq);
      mcValid   = 1'b0;
      mcId      = 6'd0;
      mcData    = 32'h0;
      if (c <= 5) begin
        mcValid = 1'b1;
        mcId    = 6'(c);
        mcData  = 32'h100 + 32'(c);
      end else if (c == 10) begin
        mcValid = 1'b1;
        mcId    = 6'd6;
        mcData  = 32'h106;
      end
      #1;
      checkOutput($sformatf("starve c%0d stall-in", c), 32'(pipeStall), 32'(stallNow));
      if (c == 1 || c == 5 || c == 10) begin
        checkOutput($sformatf("starve c%0d mcReady-in", c), 32'(mcReady), 32'(c == 1));
      end
      @(posedge clock);
      #1;
      if (stallNow) begin
        k       = (c - 1) / 9;
        expId   = 6'(k);
        expData = 32'h100 + 32'(k);
        expPend--;
      end else begin
        expId   = 6'd8;
        expData = 32'hA000_0000 + 32'(seq);
        seq++;
      end
      if (c <= 4) begin
        expPend++;
      end
      expStall = ((c % 9) == 0) && (c >= 9) && (c <= 36);
      checkOutput($sformatf("starve c%0d rdId", c),      32'(rdId),      32'(expId));
      checkOutput($sformatf("starve c%0d rdData", c),    rdData,         expData);
      checkOutput($sformatf("starve c%0d pipeStall", c), 32'(pipeStall), 32'(expStall));
      checkOutput($sformatf("starve c%0d mcPending", c), 32'(mcPending), 32'(expPend));
      checkOutput($sformatf("starve c%0d mcReady", c),   32'(mcReady),   32'(expPend < 4));
    end

`ifdef WB_BYPASS_EN
    pipeValid = 1'b1;
    pipeId    = 6'd7;
    pipeData  = 32'h77;
    mcValid   = 1'b0;
    @(posedge clock);
    #1;
    rs1Id = 6'd7;
    rs2Id = 6'h27;
    #1;
    checkOutput("bypass rs1Hit id7", 32'(rs1Hit), 32'd1);
    checkOutput("bypass rs2Hit id27", 32'(rs2Hit), 32'd0);
    pipeValid = 1'b0;
    @(posedge clock);
    #1;
    rs1Id = 6'd0;
    #1;
    checkOutput("bypass rs1Hit idle", 32'(rs1Hit), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
    $finish;
  end

endmodule
